mas_pipe: RTL

MAS_PIPE -- requirements
Module: mas_pipe

---
 rtl/mas_pipe_if.sv | 28 ++
 rtl/mas_pipe.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mas_pipe_if.sv
// Handshake and data bundle for the mas_pipe modular add/subtract pipeline.
// The master drives operations and result acceptance; the slave is the pipeline.
interface mas_pipe_if #(
  parameter int WIDTH = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic [WIDTH-1:0] q;
  logic [1:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic [WIDTH:0]   tdout;
  logic [1:0]       cmp;
  logic             err;

  modport master (
    output in_valid, din1, din2, q, sel, out_ready,
    input  in_ready, out_valid, dout, tdout, cmp, err
  );

  modport slave (
    input  in_valid, din1, din2, q, sel, out_ready,
    output in_ready, out_valid, dout, tdout, cmp, err
  );
endinterface

// File: rtl/mas_pipe.sv
// Two-stage modular add/subtract pipeline: S1 holds the raw result, S2 the corrected one.
// Define MAS_PIPE_ACC_EN to build in the accumulator, the accumulate modes and their interlock.
module mas_pipe #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  mas_pipe_if.slave  bus
);
  logic             r_s1_valid;
  logic             r_s1_sub;
  logic             r_s1_err;
  logic [WIDTH:0]   r_s1_raw;
  logic [WIDTH-1:0] r_s1_q;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH:0]   r_tdout;
  logic [1:0]       r_cmp;
  logic             r_err;

  logic             w_is_sub;
  logic             w_is_acc;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_bad;
  logic             w_interlock;
  logic [WIDTH:0]   w_raw;
  logic             w_s1_adv;
  logic             w_s1_free;
  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_dout;
  logic [1:0]       w_cmp;

  assign w_is_sub = bus.sel[1];
  assign w_is_acc = bus.sel[1] ^ bus.sel[0];

`ifdef MAS_PIPE_ACC_EN
  logic [WIDTH-1:0] r_acc;
  logic             r_s1_acc;

  // Accumulate ops use acc as A and din1 as B; acc is already updated when S1 drains.
  assign w_a         = w_is_acc ? r_acc : bus.din1;
  assign w_b         = w_is_acc ? bus.din1 : bus.din2;
  assign w_bad       = (bus.q == '0) || (w_a >= bus.q) || (w_b >= bus.q);
  assign w_interlock = r_s1_valid && r_s1_acc && w_is_acc;
`else
  assign w_a         = bus.din1;
  assign w_b         = bus.din2;
  assign w_bad       = (bus.q == '0) || (w_a >= bus.q) || (w_b >= bus.q) || w_is_acc;
  assign w_interlock = 1'b0;
`endif

  assign w_raw = w_is_sub ? ({1'b0, w_a} - {1'b0, w_b}) : ({1'b0, w_a} + {1'b0, w_b});

  assign w_s1_adv   = r_s1_valid && (!r_s2_valid || bus.out_ready);
  assign w_s1_free  = !r_s1_valid || w_s1_adv;
  assign w_in_ready = rst_n && w_s1_free && !w_interlock;
  assign w_accept   = bus.in_valid && w_in_ready;

  // Corrected values stay below q, so WIDTH-bit wraparound arithmetic is exact.
  always_comb begin
    w_dout = r_s1_raw[WIDTH-1:0];
    w_cmp  = 2'b00;
    if (r_s1_err) begin
      w_dout = '0;
      w_cmp  = 2'b11;
    end else if (!r_s1_sub) begin
      if (r_s1_raw >= {1'b0, r_s1_q}) begin
        w_dout = r_s1_raw[WIDTH-1:0] - r_s1_q;
        w_cmp  = 2'b01;
      end
    end else if (r_s1_raw[WIDTH]) begin
      w_dout = r_s1_raw[WIDTH-1:0] + r_s1_q;
      w_cmp  = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sub   <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_raw   <= '0;
      r_s1_q     <= '0;
      r_s2_valid <= 1'b0;
      r_dout     <= '0;
      r_tdout    <= '0;
      r_cmp      <= 2'b00;
      r_err      <= 1'b0;
`ifdef MAS_PIPE_ACC_EN
      r_acc      <= '0;
      r_s1_acc   <= 1'b0;
`endif
    end else begin
      if (w_s1_free) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_sub <= w_is_sub;
          r_s1_err <= w_bad;
          r_s1_raw <= w_raw;
          r_s1_q   <= bus.q;
`ifdef MAS_PIPE_ACC_EN
          r_s1_acc <= w_is_acc;
`endif
        end
      end
      if (w_s1_adv) begin
        r_s2_valid <= 1'b1;
        r_dout     <= w_dout;
        r_tdout    <= r_s1_raw;
        r_cmp      <= w_cmp;
        r_err      <= r_s1_err;
`ifdef MAS_PIPE_ACC_EN
        if (r_s1_acc && !r_s1_err) r_acc <= w_dout;
`endif
      end else if (bus.out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.dout      = r_dout;
  assign bus.tdout     = r_tdout;
  assign bus.cmp       = r_cmp;
  assign bus.err       = r_err;
endmodule
